// File: rtl/ama_riscv_pkg.sv
// Shared decode-stage definitions: immediate-generator selector encoding and
// the 32-bit immediate expansion used by every lane.
package ama_riscv_pkg;

  localparam int IG_SEL_W = 3;

  typedef logic [IG_SEL_W-1:0] ig_sel_t;

  localparam ig_sel_t IG_DISABLED = 3'd0;
  localparam ig_sel_t IG_I        = 3'd1;
  localparam ig_sel_t IG_S        = 3'd2;
  localparam ig_sel_t IG_B        = 3'd3;
  localparam ig_sel_t IG_J        = 3'd4;
  localparam ig_sel_t IG_U        = 3'd5;

  function automatic logic ig_sel_illegal(input ig_sel_t sel);
    return (sel > IG_U);
  endfunction

  // Input is inst[31:7], so instruction bit b lives at index b-7.
  function automatic logic [31:0] ig_decode32(input ig_sel_t sel, input logic [24:0] inst);
    logic [31:0] imm;
    imm = '0;
    case (sel)
      IG_I:    imm = {{20{inst[24]}}, inst[24:13]};
      IG_S:    imm = {{20{inst[24]}}, inst[24:18], inst[4:0]};
      IG_B:    imm = {{19{inst[24]}}, inst[24], inst[0], inst[23:18], inst[4:1], 1'b0};
      IG_J:    imm = {{11{inst[24]}}, inst[24], inst[12:5], inst[13], inst[23:14], 1'b0};
      IG_U:    imm = {inst[24:5], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/ama_riscv_imm_gen_lane.sv
// One immediate-generator lane: combinational decode, illegal flag and the
// hold register that DISABLED selectors replay.
module ama_riscv_imm_gen_lane
  import ama_riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  ig_sel_t         sel,
  input  logic [24:0]     inst,
  input  logic            accept,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_gen;
  logic [XLEN-1:0] hold_q;
  logic            hold_we;

  assign imm32   = ig_decode32(sel, inst);
  // Every format is sign-extended from bit 31 of the 32-bit result, U included.
  assign imm_gen = XLEN'($signed(imm32));
  assign illegal = ig_sel_illegal(sel);
  assign hold_we = accept && (sel != IG_DISABLED) && !illegal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else if (hold_we) hold_q <= imm_gen;
  end

  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    imm = imm_gen;
    if (sel == IG_DISABLED) imm = hold_q;
    else if (illegal)       imm = '0;
  end

endmodule

// File: rtl/ama_riscv_imm_gen_multi.sv
// Multi-lane immediate generator for the wide decode stage, with an optional
// single registered output stage under a valid/ready handshake.
module ama_riscv_imm_gen_multi
  import ama_riscv_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int XLEN    = 32,
  parameter int OUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [3*LANES-1:0]    ig_sel,
  input  logic [25*LANES-1:0]   ig_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN*LANES-1:0] ig_out,
  output logic [LANES-1:0]      out_illegal
);

  logic                  accept;
  logic [XLEN*LANES-1:0] imm_comb;
  logic [LANES-1:0]      ill_comb;

  // Flush vetoes the accept, so neither hold registers nor the stage update.
  assign accept = in_valid && in_ready && !flush;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ama_riscv_imm_gen_lane #(.XLEN(XLEN)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .sel     (ig_sel[IG_SEL_W*k +: IG_SEL_W]),
      .inst    (ig_in[25*k +: 25]),
      .accept  (accept),
      .imm     (imm_comb[XLEN*k +: XLEN]),
      .illegal (ill_comb[k])
    );
  end

  if (OUT_REG != 0) begin : g_reg
    logic                  valid_q;
    logic [XLEN*LANES-1:0] data_q;
    logic [LANES-1:0]      ill_q;

    assign in_ready    = !valid_q || out_ready;
    assign out_valid   = valid_q;
    assign ig_out      = data_q;
    assign out_illegal = ill_q;

    // Data registers keep their contents on flush; only valid is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        ill_q   <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        data_q  <= imm_comb;
        ill_q   <= ill_comb;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end else begin : g_comb
    assign in_ready    = out_ready;
    assign out_valid   = in_valid && !flush;
    assign ig_out      = imm_comb;
    assign out_illegal = ill_comb;
  end

endmodule

// File: doc/ama_riscv_imm_gen_multi.md
# ama_riscv_imm_gen_multi

Parametrised, multi-lane immediate generator for the wide decode stage. Each lane expands `inst[31:7]` into a sign-extended I/S/B/J/U immediate of width XLEN. An optional output register stage uses a valid/ready handshake. Per-lane hold registers replay the last generated immediate when a lane's selector is disabled. It sits between the decoder (which supplies `ig_sel`) and the operand mux / branch-target adders.

## Interface
- `LANES`, 2: number of parallel decode lanes (1..4).
- `XLEN`, 32: output width, 32 or 64; U-type and all sign extension fill to XLEN.
- `OUT_REG`, 1: 1 = registered output stage with handshake; 0 = combinational pass-through.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input bundle valid.
- `in_ready` out 1: block can accept a bundle.
- `flush` in 1: discard in-flight and incoming bundle.
- `ig_sel` in 3*LANES: per-lane selector; lane k uses `[3k+2:3k]`.
- `ig_in` in 25*LANES: per-lane instruction bits `[31:7]`; lane k uses `[25k+24:25k]`.
- `out_valid` out 1: output bundle valid.
- `out_ready` in 1: consumer accepts bundle.
- `ig_out` out XLEN*LANES: per-lane immediate.
- `out_illegal` out LANES: lane selector was illegal (6 or 7).

## Operation
- Selector encoding: DISABLED=0, I=1, S=2, B=3, J=4, U=5; 6 and 7 are illegal.
- I: `{sext(inst[31]), inst[30:20]}`.
- S: `{sext, inst[31:25], inst[11:7]}`.
- B: `{sext, inst[7], inst[30:25], inst[11:8], 0}`.
- J: `{sext, inst[19:12], inst[20], inst[30:21], 0}`.
- U: `{sext(inst[31]) to XLEN, inst[31:12], 12'b0}`; for XLEN=64, bits 63:32 replicate bit 31.
- DISABLED: lane output equals the lane hold register.
- Illegal: lane output is 0 and `out_illegal[k]` = 1.
- Hold register per lane, reset 0. Written with the lane's generated value on every accepted bundle (`in_valid && in_ready && !flush`) whose lane selector is I/S/B/J/U. Not written for DISABLED or illegal selectors.
- Lanes move as one bundle; there is no per-lane valid.
- OUT_REG=1:
  - Single output stage.
  - `in_ready = !out_valid || out_ready`.
  - On accept: capture all lanes and set `out_valid`.
  - On `out_valid && out_ready` with no new accept: clear `out_valid`.
  - Data is held stable while `out_valid && !out_ready`.
- OUT_REG=0:
  - `out_valid = in_valid && !flush`.
  - `in_ready = out_ready`.
  - Outputs are combinational from the inputs and hold registers.
- Flush:
  - Next cycle `out_valid` = 0.
  - The same-cycle input is not captured and the hold registers are not written.
  - Flush wins over a simultaneous accept.
  - Output data registers keep their old value.

## Timing
- Reset values: `out_valid` 0, `ig_out` 0, `out_illegal` 0, hold registers 0.
- `in_ready` = 1 in the first cycle after reset (OUT_REG=1).
- OUT_REG=1: latency 1 cycle (accept at edge N, visible after edge N). Throughput is 1 bundle/cycle while `out_ready` = 1.
- OUT_REG=0: latency 0 cycles. The hold-register update is visible to a DISABLED lane from the next cycle.
- A bundle mixing DISABLED lane k with write lanes reads lane k's hold value from before this bundle.
- `rst` mid-transfer drops the pending bundle; `flush` is ignored during `rst`.
- A back-pressured stage is a full stage: a new input is accepted in the same cycle the old one drains.

## Structure
- `ama_riscv_pkg` holds the IG_* selector constants, IG_SEL_W=3, and an `ig_sel_t` typedef.
- Sub-module `ama_riscv_imm_gen_lane` (parameter XLEN): combinational decode, illegal flag, hold register and its write enable. It is instantiated LANES times under a generate loop.
- The top level owns the handshake, flush logic and the output register stage.

## Test plan
- XLEN=32, lane0 I with `addi` 0xFFF00093, lane1 S with `sw` 0xFE112E23 -> next cycle `ig_out` lane0 0xFFFFFFFF, lane1 0xFFFFFFFC, `out_valid` 1.
- Lane0 B with `beq` 0x00000463 -> 0x00000008. Lane1 J with `jal` 0xFFDFF06F -> 0xFFFFFFFC. Next bundle both DISABLED -> 0x00000008 / 0xFFFFFFFC repeated.
- XLEN=64, U with `lui` 0x800000B7 -> 0xFFFFFFFF80000000. U with 0x123450B7 -> 0x0000000012345000.
- `out_ready` = 0 for 3 cycles with `in_valid` held -> `in_ready` 0 and `ig_out` stable. Release -> one bundle per cycle with no loss or duplication.
- Flush coincident with an accept of lane0 I 0x00100093 -> `out_valid` 0 next cycle. A following DISABLED bundle returns the previous hold value, not 0x00000001.
- Selector 7 on lane1 -> `ig_out` lane1 0 and `out_illegal` 2'b10, hold unchanged. Assert `rst` with `out_valid` = 1 -> all outputs 0 next cycle.
